// File: rtl/mem_msgs_pkg.sv
// mem_msgs_pkg: 4-byte memory request/response message types and byte-mask helper
package mem_msgs_pkg;
    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_READ   = 3'd0;
    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_WRITE  = 3'd1;
    localparam logic [2:0] VC_MEM_RESP_MSG_TYPE_READ  = 3'd0;
    localparam logic [2:0] VC_MEM_RESP_MSG_TYPE_WRITE = 3'd1;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // len 0 encodes a full word; 1..3 select that many low bytes
    function automatic logic [3:0] len_to_bmask(input logic [1:0] len);
        return len == 2'd0 ? 4'b1111 : len == 2'd1 ? 4'b0001 : len == 2'd2 ? 4'b0011 : 4'b0111;
    endfunction
endpackage

// File: rtl/mem_byte_ram.sv
// mem_byte_ram: single-port word RAM with per-byte write enables and combinational read
module mem_byte_ram #(
    parameter int NUM_WORDS = 1024,
    localparam int ADDR_W = $clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [NUM_WORDS];

    always_ff @(posedge clk)
        for (int b = 0; b < 4; b++)
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];

    assign rdata = mem[addr];
endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: val/rdy memory target answering one request at a time after a fixed latency
module cache_mem_responder
    import mem_msgs_pkg::*;
#(
    parameter int LATENCY   = 2,
    parameter int NUM_WORDS = 1024,
    localparam int ADDR_W = $clog2(NUM_WORDS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cachereq_val,
    output logic         cachereq_rdy,
    input  mem_req_4B_t  cachereq_msg,
    output logic         cacheresp_val,
    input  logic         cacheresp_rdy,
    output mem_resp_4B_t cacheresp_msg
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        req_fire, resp_fire, is_wr;
    logic [3:0]  bmask;
    logic [31:0] rdata, lane_mask;
    logic        unused_addr_bits;

    assign req_fire  = state == IDLE && cachereq_rdy && cachereq_val;
    assign resp_fire = state == RESP && cacheresp_val && cacheresp_rdy;
    assign is_wr     = cachereq_msg.type_ == VC_MEM_REQ_MSG_TYPE_WRITE;
    assign bmask     = len_to_bmask(cachereq_msg.len);
    assign lane_mask = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
    assign unused_addr_bits = ^{cachereq_msg.addr[31:ADDR_W+2], cachereq_msg.addr[1:0]};

    // writes commit on the acceptance edge; reads sample the same cycle
    mem_byte_ram #(.NUM_WORDS(NUM_WORDS)) u_ram (
        .clk   (clk),
        .we    (req_fire && is_wr ? bmask : 4'b0000),
        .addr  (cachereq_msg.addr[ADDR_W+1:2]),
        .wdata (cachereq_msg.data),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cachereq_rdy  <= 1'b0;
            cacheresp_val <= 1'b0;
            cacheresp_msg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        cachereq_rdy  <= 1'b0;
                        cnt           <= 4'(LATENCY - 1);
                        cacheresp_msg <= '{
                            type_:  is_wr ? VC_MEM_RESP_MSG_TYPE_WRITE : VC_MEM_RESP_MSG_TYPE_READ,
                            opaque: cachereq_msg.opaque,
                            test:   2'd0,
                            len:    cachereq_msg.len,
                            data:   is_wr ? 32'd0 : rdata & lane_mask
                        };
                        state         <= LATENCY == 1 ? RESP : WAIT;
                        cacheresp_val <= LATENCY == 1;
                    end else begin
                        cachereq_rdy <= 1'b1;
                    end
                end
                // leave on the edge where the counter reaches zero
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state         <= RESP;
                        cacheresp_val <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_fire) begin
                        state         <= IDLE;
                        cacheresp_val <= 1'b0;
                        cachereq_rdy  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
